// File: rtl/ins_ram.sv
// ins_ram: instruction memory with a wait-state read controller feeding the cpu core.
// Fetches are accepted only in IDLE. Each accepted fetch returns one en_ram_out strobe
// WAIT_CYCLES+1 cycles after the request was sampled.
// A load port writes the program image. A load wins over a fetch in the same IDLE cycle.
// Optional feature macro: INS_RAM_PREFETCH_EN. When it is defined, the word after the
// last fetch is prefetched, and a sequential fetch that hits it answers in one cycle.
//
// Handshake: en_ram_in is sampled only while busy=0. The core must hold or reissue a
// request that is not taken. load_we is honoured only while busy=0, and the loader must
// hold it until load_ack, which pulses the cycle after the write lands. en_ram_out and
// err are single-cycle pulses. ins holds its value between responses.
module ins_ram #(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_ram_in,
  input  logic [15:0]   addr,
  output logic [15:0]   ins,
  output logic          en_ram_out,
  output logic          busy,
  output logic          err,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          load_ack,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [15:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic        wr_en;
  logic        cap;
  logic        pf_hit;
  logic [15:0] pf_word;
  logic [15:0] rd_addr;
  logic        rd_in_range;
  logic [15:0] rd_word;

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  // In IDLE the response can be produced on the capture edge, so the live address is used.
  assign rd_addr     = (state_q == ST_IDLE) ? addr : addr_q;
  assign rd_in_range = (rd_addr < 16'(DEPTH));
  assign rd_word     = mem[rd_addr[AW-1:0]];

`ifdef INS_RAM_PREFETCH_EN
  logic        pf_valid_q;
  logic [15:0] pf_addr_q;
  logic [15:0] pf_data_q;
  logic [15:0] next_addr;

  assign next_addr = addr_q + 16'd1;
  assign pf_hit    = pf_valid_q && (addr == pf_addr_q);
  assign pf_word   = pf_data_q;

  // Prefetch the next word when leaving RESP, and drop it on a write to that word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_valid_q <= 1'b0;
      pf_addr_q  <= 16'h0000;
      pf_data_q  <= 16'h0000;
    end else if (state_q == ST_RESP) begin
      if (({1'b0, addr_q} + 17'd1) < 17'(DEPTH)) begin
        pf_valid_q <= 1'b1;
        pf_addr_q  <= next_addr;
        pf_data_q  <= mem[next_addr[AW-1:0]];
      end else begin
        pf_valid_q <= 1'b0;
      end
    end else if (wr_en && ({{(16-AW){1'b0}}, load_addr} == pf_addr_q)) begin
      pf_valid_q <= 1'b0;
    end
  end
`else
  assign pf_hit  = 1'b0;
  assign pf_word = 16'h0000;
`endif

  // Memory write port. The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[load_addr] <= load_data;
  end

  // FSM state, wait counter and captured fetch address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) addr_q <= addr;
    end
  end

  // Next-state logic. A load has priority, and the fetch waits for a later IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_we) begin
          wr_en = 1'b1;
        end else if (en_ram_in) begin
          cap = 1'b1;
          if (pf_hit || (WAIT_CYCLES == 0)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers are loaded on the edge that enters RESP, and load_ack trails the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins        <= 16'h0000;
      en_ram_out <= 1'b0;
      err        <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= wr_en;
      if (state_d == ST_RESP) begin
        en_ram_out <= 1'b1;
        err        <= !rd_in_range;
        if (!rd_in_range)                      ins <= 16'h0000;
        else if (state_q == ST_IDLE && pf_hit) ins <= pf_word;
        else                                   ins <= rd_word;
      end else begin
        en_ram_out <= 1'b0;
        err        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ins_ram.sv
// tb_ins_ram: directed and random fetch/load traffic for ins_ram.
// Two instances are used: the default WAIT_CYCLES=2, and a zero-wait copy.
module tb_ins_ram;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_ram_in, load_we, en_ram_out, busy, err, load_ack;
  logic [15:0] addr, ins, load_data;
  logic [7:0]  load_addr;
  logic [1:0]  state_dbg;

  logic        z_en_ram_in, z_load_we, z_en_ram_out, z_busy, z_err, z_load_ack;
  logic [15:0] z_addr, z_ins, z_load_data;
  logic [7:0]  z_load_addr;
  logic [1:0]  z_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [256];
  logic [15:0] exp_q [$];
  logic        m_pf_valid = 1'b0;
  int          m_pf_addr  = 0;

  ins_ram #(.DEPTH(256), .AW(8), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ins(ins),
    .en_ram_out(en_ram_out), .busy(busy), .err(err), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .state_dbg(state_dbg)
  );

  ins_ram #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .en_ram_in(z_en_ram_in), .addr(z_addr), .ins(z_ins),
    .en_ram_out(z_en_ram_out), .busy(z_busy), .err(z_err), .load_we(z_load_we),
    .load_addr(z_load_addr), .load_data(z_load_data), .load_ack(z_load_ack),
    .state_dbg(z_state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Reference latency: a prefetch hit answers in one cycle, and anything else takes W+1.
  function automatic int exp_lat(input int a);
`ifdef INS_RAM_PREFETCH_EN
    if (m_pf_valid && a == m_pf_addr) return 1;
`endif
    return W + 1;
  endfunction

  task automatic model_after_fetch(input int a);
    if (a + 1 < 256) begin
      m_pf_valid = 1'b1;
      m_pf_addr  = a + 1;
    end else begin
      m_pf_valid = 1'b0;
    end
  endtask

  task automatic model_write(input int a, input logic [15:0] d);
    m_mem[a] = d;
    if (m_pf_valid && a == m_pf_addr) m_pf_valid = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input int a);
    return (a < 256) ? m_mem[a] : 16'h0000;
  endfunction

  // driver: program-image write on the main instance, held until acknowledged
  task automatic load_a(input int a, input logic [15:0] d);
    int cyc;
    @(negedge clk);
    load_we = 1'b1; load_addr = 8'(a); load_data = d;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!load_ack && cyc < 20);
    load_we = 1'b0;
    check("load_ack", {31'b0, load_ack}, 32'd1);
    check("load_lat", cyc, 1);
    model_write(a, d);
  endtask

  // driver: single fetch on the main instance, checked against the model and the scoreboard
  task automatic fetch_a(input int a);
    int lat, bn, el;
    logic [15:0] got;
    el = exp_lat(a);
    exp_q.push_back(model_read(a));
    @(negedge clk);
    en_ram_in = 1'b1; addr = 16'(a);
    @(negedge clk);
    en_ram_in = 1'b0;
    lat = 1; bn = int'(busy);
    while (!en_ram_out && lat < 40) begin
      @(negedge clk); lat++; bn += int'(busy);
    end
    got = ins;
    check("fetch_strobe", {31'b0, en_ram_out}, 32'd1);
    check("fetch_lat", lat, el);
    check("fetch_busy", bn, el);
    check("fetch_ins", got, exp_q.pop_front());
    check("fetch_err", {31'b0, err}, (a >= 256) ? 32'd1 : 32'd0);
    model_after_fetch(a);
    @(negedge clk);
    check("strobe_pulse", {31'b0, en_ram_out}, 32'd0);
    check("ins_hold", ins, got);
  endtask

  task automatic z_load(input int a, input logic [15:0] d);
    int cyc;
    @(negedge clk);
    z_load_we = 1'b1; z_load_addr = 8'(a); z_load_data = d;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!z_load_ack && cyc < 20);
    z_load_we = 1'b0;
    check("z_load_ack", {31'b0, z_load_ack}, 32'd1);
  endtask

  task automatic z_fetch(input int a, input logic [15:0] d);
    int lat, bn;
    @(negedge clk);
    z_en_ram_in = 1'b1; z_addr = 16'(a);
    @(negedge clk);
    z_en_ram_in = 1'b0;
    lat = 1; bn = int'(z_busy);
    while (!z_en_ram_out && lat < 40) begin
      @(negedge clk); lat++; bn += int'(z_busy);
    end
    check("z_lat", lat, 1);
    check("z_busy_cycles", bn, 1);
    check("z_ins", z_ins, d);
    check("z_err", {31'b0, z_err}, 32'd0);
    @(negedge clk);
    check("z_strobe_pulse", {31'b0, z_en_ram_out}, 32'd0);
    check("z_idle", {31'b0, z_busy}, 32'd0);
  endtask

  initial begin
    int lat, cyc, last;
    logic [15:0] d, d_old;
    logic seen, ack_busy;

    // reset
    rst = 1'b0;
    en_ram_in = 1'b0; addr = 16'h0; load_we = 1'b0; load_addr = 8'h0; load_data = 16'h0;
    z_en_ram_in = 1'b0; z_addr = 16'h0; z_load_we = 1'b0; z_load_addr = 8'h0; z_load_data = 16'h0;
    #1;
    check("rst_ins", ins, 16'h0000);
    check("rst_out", {31'b0, en_ram_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ack", {31'b0, load_ack}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    check("z_rst_ins", z_ins, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // full program image, with a known two-word program at the bottom
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      load_a(i, 16'h0458);
      else if (i == 1) load_a(i, 16'h2846);
      else             load_a(i, 16'($urandom));
    end

    // basic fetches, and out-of-range addresses with upper bits set
    fetch_a(0);
    fetch_a(1);
    fetch_a(16'h0100);
    fetch_a(16'hFFFF);

    // zero-wait instance
    z_load(0, 16'h0458);
    z_load(1, 16'h2846);
    z_fetch(1, 16'h2846);
    z_fetch(0, 16'h0458);

    // load and fetch in the same IDLE cycle: the write goes first and the fetch sees it
    d = 16'($urandom);
    lat = exp_lat(32'h20);
    @(negedge clk);
    load_we = 1'b1; load_addr = 8'h20; load_data = d;
    en_ram_in = 1'b1; addr = 16'h0020;
    @(negedge clk);
    check("coll_ack", {31'b0, load_ack}, 32'd1);
    check("coll_idle", {31'b0, busy}, 32'd0);
    load_we = 1'b0;
    model_write(32'h20, d);
    lat = exp_lat(32'h20);
    @(negedge clk);
    en_ram_in = 1'b0;
    cyc = 1;
    while (!en_ram_out && cyc < 40) begin @(negedge clk); cyc++; end
    check("coll_lat", cyc, lat);
    check("coll_ins", ins, d);
    model_after_fetch(32'h20);
    @(negedge clk);

    // load held while busy: no write until the fetch has finished
    d_old = m_mem[8'h30];
    d = ~d_old;
    lat = exp_lat(32'h30);
    @(negedge clk);
    en_ram_in = 1'b1; addr = 16'h0030;
    @(negedge clk);
    en_ram_in = 1'b0;
    load_we = 1'b1; load_addr = 8'h30; load_data = d;
    cyc = 1; ack_busy = 1'b0;
    while (!en_ram_out && cyc < 40) begin
      @(negedge clk); cyc++;
      if (load_ack) ack_busy = 1'b1;
    end
    check("busyload_lat", cyc, lat);
    check("busyload_old_ins", ins, d_old);
    model_after_fetch(32'h30);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!load_ack && cyc < 20);
    load_we = 1'b0;
    check("busyload_ack", {31'b0, load_ack}, 32'd1);
    check("busyload_no_early_ack", {31'b0, ack_busy}, 32'd0);
    check("busyload_ack_delay", cyc, 2);
    model_write(32'h30, d);
    fetch_a(32'h30);

    // sequential fetch pair, then the same pair with the second word rewritten in between
    fetch_a(4);
    fetch_a(5);
    fetch_a(4);
    load_a(5, 16'($urandom));
    fetch_a(5);

    // reset in the middle of a fetch
    @(negedge clk);
    en_ram_in = 1'b1; addr = 16'h0002;
    @(negedge clk);
    en_ram_in = 1'b0;
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ins", ins, 16'h0000);
    check("midrst_out", {31'b0, en_ram_out}, 32'd0);
    check("midrst_state", {30'b0, state_dbg}, 32'd0);
    m_pf_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (en_ram_out) seen = 1'b1; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (en_ram_out) seen = 1'b1; end
    check("midrst_no_strobe", {31'b0, seen}, 32'd0);
    fetch_a(0);
    fetch_a(1);

    // random traffic
    last = 1;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        load_a($urandom_range(0, 255), 16'($urandom));
      end else if (r < 5) begin
        last = last + 1;
        fetch_a(last);
      end else if (r == 5) begin
        fetch_a($urandom_range(256, 65535));
      end else begin
        last = $urandom_range(0, 255);
        fetch_a(last);
      end
      if (last > 255) last = 0;
    end

    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_ram.md
Name: ins_ram

Overview:
- Instruction memory with wait-state read controller, directly upstream of the cpu core.
- Serves the core's 16-bit instruction fetches: the core raises en_ram_in with addr, and this block returns ins with a one-cycle en_ram_out strobe after a programmable number of wait states.
- A separate load port lets a bench or boot loader write the program image before or between fetches.

Parameters:
- DEPTH, 256, number of 16-bit instruction words (power of two, 16..4096).
- AW, 8, load address width (log2 DEPTH).
- WAIT_CYCLES, 2, read wait states inserted before the response (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- en_ram_in  input  1  fetch request from cpu, sampled only in IDLE.
- addr  input  16  fetch word address from cpu, captured with request.
- ins  output  16  fetched instruction word, held stable until the next response.
- en_ram_out  output  1  response strobe, high exactly one cycle per accepted fetch.
- busy  output  1  high while a fetch is in flight (WAIT or RESP).
- err  output  1  one-cycle pulse with en_ram_out when the captured addr >= DEPTH.
- load_we  input  1  program-image write strobe.
- load_addr  input  AW  write word address.
- load_data  input  16  write data.
- load_ack  output  1  one-cycle pulse the cycle after a write is committed.

Behaviour:
- Reset (rst=0, async): ins=16'h0000, en_ram_out=0, busy=0, err=0, load_ack=0, FSM=IDLE, wait counter=0. Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - load_we=1 → write mem[load_addr]=load_data; load_ack=1 next cycle; stay IDLE.
  - else en_ram_in=1 → capture addr into addr_q.
    - WAIT_CYCLES=0 → RESP.
    - otherwise → WAIT with counter=WAIT_CYCLES-1.
  - A load takes priority over a fetch in the same cycle. The fetch is not lost; it is taken next cycle if en_ram_in is still high.
- WAIT: counter decrements each cycle; at 0 → RESP.
- RESP:
  - en_ram_out=1 for this single cycle.
  - ins updates on entry: mem[addr_q[AW-1:0]] if addr_q<DEPTH, else 16'h0000 with err=1.
  - Always → IDLE.
- Latency: request sampled at edge N; en_ram_out high during cycle N+1+WAIT_CYCLES. Back-to-back fetches are possible, with minimum spacing WAIT_CYCLES+2 cycles.
- en_ram_in is ignored while busy=1. No queuing; the core must hold the request or reissue it.
- load_we while busy=1: the write is not performed and load_ack stays 0. The loader must hold load_we until load_ack.
- Read-after-write to the same address returns the new data (the write commits before any later fetch capture).
- Address wrap: no wrap. Upper addr bits beyond AW make the address out of range (see RESP).
- Reset mid-fetch: the in-flight fetch is aborted, no en_ram_out is produced, and outputs return to reset values immediately.
- ins holds its last value whenever en_ram_out=0.

Optional Feature:
- Macro: INS_RAM_PREFETCH_EN.
- Defined:
  - On leaving RESP, the block reads mem[addr_q+1] into a prefetch register and sets pf_valid.
  - A subsequent IDLE fetch with addr==addr_q+1 and pf_valid=1 is a hit: it skips WAIT and goes straight to RESP, for a latency of 1 cycle regardless of WAIT_CYCLES.
  - Any committed write to the prefetched address, or reset, clears pf_valid.
  - A miss behaves as in the baseline.
  - The prefetch is not performed when addr_q+1 >= DEPTH.
- Undefined: no prefetch register; every fetch takes WAIT_CYCLES+1 cycles.

Test Plan:
- Load/fetch: load mem[0]=16'h0458 (MOV R1,#0x58) and mem[1]=16'h2846; fetch addr 0 with WAIT_CYCLES=2 → en_ram_out high 3 cycles after request, ins=16'h0458, err=0.
- Zero-wait: WAIT_CYCLES=0, fetch addr 1 → en_ram_out the next cycle, ins=16'h2846; busy high exactly 1 cycle.
- Out of range: fetch addr 16'h0100 with DEPTH=256 → en_ram_out=1, err=1, ins=16'h0000.
- Load/fetch collision:
  - load_we and en_ram_in in the same IDLE cycle → the write commits and load_ack pulses; the fetch is served afterwards and returns the newly written word.
  - load_we held during busy → no write until IDLE, then load_ack.
- Reset mid-fetch: drop rst in WAIT → en_ram_out never asserts, ins=0, busy=0.
  - Re-fetch after release returns the memory contents intact.
- Prefetch (with INS_RAM_PREFETCH_EN): fetch addr 4, then addr 5 → second response 1 cycle after request.
  - Writing mem[5] between the two fetches forces full latency and returns the new data.
